agc_out_packer: RTL and testbench
=================================

// Module: agc_out_packer
// PURPOSE
//  Consumer of the AGC gain-stage output (Valid_Out / OutputI / OutputQ, Q26.18 two's complement).
//  - Rounds and saturates each I/Q sample to the Q16.14 channel format.
//  - Buffers samples in a first-word-fall-through (FWFT) FIFO.
//  - Presents them on an AXI-Stream master with tready backpressure.
//  - Counts saturation events and samples dropped on FIFO overflow.
//  - Sits between the AGC loop and the downstream channel consumer.
// PARAMETERS
//  W_IN_MODULE  26  input sample width, Q26.18
//  W_OUT        16  output sample width, Q16.14
//  FRAC_DROP     4  LSBs removed (18-14)
//  DEPTH        16  FIFO entries, power of 2, >=2
//  CNTWIDTH     16  width of ovf_cnt / drop_cnt
// PORTS
//  clk            in   1            system clock, rising edge
//  rst            in   1            asynchronous reset, active-high
//  s_valid        in   1            input sample strobe (AGC Valid_Out)
//  s_dataI        in   W_IN_MODULE  I sample, Q26.18 signed
//  s_dataQ        in   W_IN_MODULE  Q sample, Q26.18 signed
//  m_axis_tdata   out  2*W_OUT      {Q[15:0], I[15:0]}
//  m_axis_tvalid  out  1            output word valid
//  m_axis_tready  in   1            downstream ready
//  cnt_clr        in   1            synchronous clear of ovf_cnt and drop_cnt
//  ovf_cnt        out  CNTWIDTH     samples where I or Q saturated
//  drop_cnt       out  CNTWIDTH     samples lost while FIFO full
//  fifo_level     out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - FIFO flushed; m_axis_tvalid=0, m_axis_tdata=0.
//    - ovf_cnt=0, drop_cnt=0, fifo_level=0; stage-1 valid=0.
//    - Reset mid-burst discards all buffered and in-flight samples.
//  - Stage 1, 1 clk, registered:
//    - Sign-extend input to 27 b.
//    - Optionally add rounding constant (see CONFIGURATION).
//    - Arithmetic shift right FRAC_DROP.
//    - Saturate to [-32768, +32767] (0x8000 / 0x7FFF).
//    - sat_flag = I or Q clipped.
//  - Stage 2, FIFO write:
//    - Stage-1 valid writes {Q,I} on the next edge.
//    - Empty FIFO with tready=1: s_valid at edge N gives m_axis_tvalid=1 after edge N+2 (latency 2 clk).
//  - Handshake:
//    - Transfer when tvalid & tready.
//    - tdata and tvalid held stable while tvalid & !tready.
//    - Words emerge in input order; no gaps are inserted while the FIFO is non-empty.
//  - Boundaries:
//    - FIFO full, write without read: sample dropped; drop_cnt+1.
//    - FIFO full, write with read in the same cycle: write accepted; level unchanged.
//    - FIFO empty, write in the same cycle: no read occurs; tvalid rises on the next edge.
//    - Pointers wrap modulo DEPTH.
//  - Counters:
//    - ovf_cnt +1 per accepted-or-dropped sample with sat_flag.
//    - Both counters saturate at all-ones, never wrap.
//    - cnt_clr has priority over same-cycle increment.
//  - s_valid is accepted every clk; the block never stalls the AGC.
// CONFIGURATION
//  AGC_OUT_ROUND_EN defined:
//    - Round half up: add 2^(FRAC_DROP-1)=8 before the shift.
//    - Saturation is evaluated after the add, so rounding into overflow clips.
//  AGC_OUT_ROUND_EN undefined:
//    - Plain truncation toward -inf; the adder is removed.
// TESTING
//  1. I=0x0040000 (1.0), Q=0x3FC0000 (-1.0) -> tdata=0xC0004000, ovf_cnt=0, latency 2 clk.
//  2. I=0x00C0000 (3.0), Q=0x3F00000 (-4.0) -> I=0x7FFF, Q=0x8000, ovf_cnt=1.
//  3. I=0x0000008, Q=0x3FFFFF8 -> ROUND_EN: I=0x0001, Q=0x0000; no ROUND_EN: I=0x0000, Q=0xFFFF.
//  4. tready=0, DEPTH=16, 20 consecutive samples:
//     - fifo_level=16, drop_cnt=4.
//     - Then tready=1 drains the first 16 samples in order, back-to-back.
//  5. FIFO full, tready=1 with s_valid in the same cycle -> no drop, level stays 16.
//  6. rst pulse mid-burst at level 7 -> tvalid=0, level=0, counters=0 within the same cycle;
//     next sample appears 2 clk after its s_valid.

Source files
------------

// File: rtl/agc_out_packer_if.sv
// AXI-Stream style output channel of the AGC output packer: {Q,I} word, valid, ready.
interface agc_out_packer_if #(
  parameter int W_OUT = 16
) ();
  logic [2*W_OUT-1:0] tdata;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/agc_out_packer.sv
// AGC output packer: Q26.18 -> Q16.14 round/saturate, FWFT FIFO, AXI-Stream out, event counters.
// Define AGC_OUT_ROUND_EN for round-half-up; otherwise samples are truncated toward -inf.
module agc_out_packer #(
  parameter int W_IN_MODULE = 26,
  parameter int W_OUT       = 16,
  parameter int FRAC_DROP   = 4,
  parameter int DEPTH       = 16,
  parameter int CNTWIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [W_IN_MODULE-1:0]     s_dataI,
  input  logic [W_IN_MODULE-1:0]     s_dataQ,
  agc_out_packer_if.master           m_axis,
  input  logic                       cnt_clr,
  output logic [CNTWIDTH-1:0]        ovf_cnt,
  output logic [CNTWIDTH-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int EXT_W = W_IN_MODULE + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (W_OUT-1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef AGC_OUT_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(1 << (FRAC_DROP-1));
`endif

  // Returns {clipped, sample}; the rounding add happens before the clip test.
  function automatic logic [W_OUT:0] conv(input logic [W_IN_MODULE-1:0] x);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] sh;
    logic [W_OUT:0]          r;
    ext = $signed({x[W_IN_MODULE-1], x});
`ifdef AGC_OUT_ROUND_EN
    ext = ext + RND;
`endif
    sh = ext >>> FRAC_DROP;
    if (sh > SAT_MAX)      r = {1'b1, SAT_MAX[W_OUT-1:0]};
    else if (sh < SAT_MIN) r = {1'b1, SAT_MIN[W_OUT-1:0]};
    else                   r = {1'b0, sh[W_OUT-1:0]};
    return r;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [W_OUT-1:0]     s1_i_q, s1_i_d;
  logic [W_OUT-1:0]     s1_q_q, s1_q_d;
  logic                 s1_sat_q, s1_sat_d;
  logic [2*W_OUT-1:0]   mem_q [DEPTH];
  logic [2*W_OUT-1:0]   mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [CNTWIDTH-1:0]  ovf_q, ovf_d;
  logic [CNTWIDTH-1:0]  drop_q, drop_d;
  logic [W_OUT:0]       conv_i, conv_q;
  logic                 tvalid, full, rd_en, wr_en, drop;

  always_comb begin
    conv_i     = conv(s_dataI);
    conv_q     = conv(s_dataQ);
    s1_valid_d = s_valid;
    s1_i_d     = conv_i[W_OUT-1:0];
    s1_q_d     = conv_q[W_OUT-1:0];
    s1_sat_d   = conv_i[W_OUT] | conv_q[W_OUT];
  end

  // A full FIFO still accepts a write when the same edge pops a word.
  always_comb begin
    tvalid = (level_q != '0);
    full   = (level_q == LW'(DEPTH));
    rd_en  = tvalid & m_axis.tready;
    wr_en  = s1_valid_q & (~full | rd_en);
    drop   = s1_valid_q & full & ~rd_en;

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = {s1_q_q, s1_i_q};
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (cnt_clr) begin
      ovf_d  = '0;
      drop_d = '0;
    end else begin
      if (s1_valid_q && s1_sat_q && !(&ovf_q)) ovf_d  = ovf_q + 1'b1;
      if (drop && !(&drop_q))                 drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_sat_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      drop_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
      s1_sat_q   <= s1_sat_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    m_axis.tvalid = tvalid;
    m_axis.tdata  = mem_q[rd_ptr_q];
    ovf_cnt       = ovf_q;
    drop_cnt      = drop_q;
    fifo_level    = level_q;
  end

endmodule

// File: tb/tb_agc_out_packer.sv
// Self-checking bench for agc_out_packer: queue-based reference model plus directed literal checks.
module tb_agc_out_packer;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int LW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid = 1'b0;
  logic [25:0]    s_dataI = '0;
  logic [25:0]    s_dataQ = '0;
  logic           cnt_clr = 1'b0;
  logic [CW-1:0]  ovf_cnt;
  logic [CW-1:0]  drop_cnt;
  logic [LW-1:0]  fifo_level;

  agc_out_packer_if #(.W_OUT(16)) axis ();

  always #5 clk = ~clk;

  agc_out_packer #(
    .W_IN_MODULE(26), .W_OUT(16), .FRAC_DROP(4), .DEPTH(DEPTH), .CNTWIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_dataI(s_dataI), .s_dataQ(s_dataQ),
    .m_axis(axis), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion: real-valued floor(x/16) (optionally of x+8), clamped to 16-bit range.
  function automatic logic [15:0] ref_conv(input logic [25:0] x, output bit sat);
    longint v;
    longint f;
    v = longint'($signed(x));
`ifdef AGC_OUT_ROUND_EN
    v = v + 8;
`endif
    f = v / 16;
    if (v < 0 && (v % 16) != 0) f = f - 1;
    sat = 1'b0;
    if (f > 32767) begin
      f = 32767;
      sat = 1'b1;
    end else if (f < -32768) begin
      f = -32768;
      sat = 1'b1;
    end
    return f[15:0];
  endfunction

  function automatic logic [25:0] rand_sample();
    logic [25:0] r;
    case ($urandom_range(0, 2))
      0:       r = 26'($urandom);
      1:       r = 26'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      default: r = 26'(int'($urandom_range(0, 64)) - 32);
    endcase
    return r;
  endfunction

  // Model state: FIFO contents as a queue, one-deep pipeline slot, counters.
  logic [31:0] mq[$];
  int unsigned ovf_m  = 0;
  int unsigned drop_m = 0;
  bit          pend_v = 1'b0;
  bit          pend_sat = 1'b0;
  logic [31:0] pend_w = '0;

  initial begin
    bit dropped;
    bit si, sq;
    logic [15:0] ri, rq;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        ovf_m  = 0;
        drop_m = 0;
        pend_v = 1'b0;
      end else begin
        dropped = 1'b0;
        if (mq.size() != 0 && axis.tready) void'(mq.pop_front());
        if (pend_v) begin
          if (mq.size() < DEPTH) mq.push_back(pend_w);
          else dropped = 1'b1;
        end
        if (cnt_clr) begin
          ovf_m  = 0;
          drop_m = 0;
        end else begin
          if (pend_v && pend_sat && ovf_m < CMAX) ovf_m++;
          if (dropped && drop_m < CMAX) drop_m++;
        end
        pend_v = s_valid;
        if (s_valid) begin
          ri = ref_conv(s_dataI, si);
          rq = ref_conv(s_dataQ, sq);
          pend_w   = {rq, ri};
          pend_sat = si | sq;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("tvalid", 32'(axis.tvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) checkOutput("tdata", axis.tdata, mq[0]);
      else if (rst) checkOutput("tdata_rst", axis.tdata, 32'h0);
      checkOutput("fifo_level", 32'(fifo_level), 32'(mq.size()));
      checkOutput("ovf_cnt", 32'(ovf_cnt), ovf_m);
      checkOutput("drop_cnt", 32'(drop_cnt), drop_m);
    end
  end

  task automatic applyStimulus(input bit v, input logic [25:0] di, input logic [25:0] dq,
                               input bit rdy, input bit clr);
    @(negedge clk);
    #1;
    s_valid     = v;
    s_dataI     = di;
    s_dataQ     = dq;
    axis.tready = rdy;
    cnt_clr     = clr;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pct;
    rst = 1'b1;
    axis.tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 32'(axis.tvalid), 32'h0);
    checkOutput("rst_tdata", axis.tdata, 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    checkOutput("rst_ovf", 32'(ovf_cnt), 32'h0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    // +1.0 / -1.0, two-clock latency into an empty FIFO
    applyStimulus(1, 26'h0040000, 26'h3FC0000, 1, 0);
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t1_lat1_tvalid", 32'(axis.tvalid), 32'h0);
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t1_tvalid", 32'(axis.tvalid), 32'h1);
    checkOutput("t1_tdata", axis.tdata, 32'hC0004000);
    checkOutput("t1_ovf", 32'(ovf_cnt), 32'h0);

    // +3.0 / -4.0 both clip
    applyStimulus(1, 26'h00C0000, 26'h3F00000, 1, 0);
    applyStimulus(0, '0, '0, 1, 0);
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t2_tdata", axis.tdata, 32'h80007FFF);
    checkOutput("t2_ovf", 32'(ovf_cnt), 32'h1);

    // +8 / -8 LSBs: rounding vs truncation
    applyStimulus(1, 26'h0000008, 26'h3FFFFF8, 1, 0);
    applyStimulus(0, '0, '0, 1, 0);
    applyStimulus(0, '0, '0, 1, 0);
`ifdef AGC_OUT_ROUND_EN
    checkOutput("t3_tdata", axis.tdata, 32'h00000001);
`else
    checkOutput("t3_tdata", axis.tdata, 32'hFFFF0000);
`endif

    // 20 samples into a stalled FIFO, then drain
    applyStimulus(0, '0, '0, 1, 1);
    for (int k = 0; k < 20; k++) applyStimulus(1, rand_sample(), rand_sample(), 0, 0);
    applyStimulus(0, '0, '0, 0, 0);
    applyStimulus(0, '0, '0, 0, 0);
    checkOutput("t4_level", 32'(fifo_level), 32'd16);
    checkOutput("t4_drop", 32'(drop_cnt), 32'd4);
    repeat (18) applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t4_drained", 32'(fifo_level), 32'd0);

    // Full FIFO: simultaneous pop and push keep the level at 16 without drops
    for (int k = 0; k < 16; k++) applyStimulus(1, rand_sample(), rand_sample(), 0, 0);
    applyStimulus(0, '0, '0, 0, 0);
    applyStimulus(0, '0, '0, 0, 0);
    applyStimulus(1, rand_sample(), rand_sample(), 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, rand_sample(), rand_sample(), 1, 0);
      checkOutput("t5_level", 32'(fifo_level), 32'd16);
      checkOutput("t5_drop", 32'(drop_cnt), 32'd4);
    end
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t5_level_end", 32'(fifo_level), 32'd16);
    repeat (20) applyStimulus(0, '0, '0, 1, 0);

    // Reset in the middle of a burst at level 7
    for (int k = 0; k < 9; k++) applyStimulus(1, rand_sample(), rand_sample(), 0, 0);
    checkOutput("t6_level_pre", 32'(fifo_level), 32'd7);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_tvalid", 32'(axis.tvalid), 32'h0);
    checkOutput("t6_level", 32'(fifo_level), 32'h0);
    checkOutput("t6_ovf", 32'(ovf_cnt), 32'h0);
    checkOutput("t6_drop", 32'(drop_cnt), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    s_valid = 1'b0;
    applyStimulus(1, 26'h0040000, 26'h3FC0000, 1, 0);
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t6_lat1_tvalid", 32'(axis.tvalid), 32'h0);
    applyStimulus(0, '0, '0, 1, 0);
    checkOutput("t6_tvalid_after", 32'(axis.tvalid), 32'h1);
    checkOutput("t6_tdata_after", axis.tdata, 32'hC0004000);

    // Randomised traffic with varying backpressure and occasional counter clears
    for (int n = 0; n < 2500; n++) begin
      case (n / 500)
        0:       pct = 90;
        1:       pct = 30;
        2:       pct = 60;
        3:       pct = 10;
        default: pct = 100;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, rand_sample(), rand_sample(),
                    $urandom_range(0, 99) < pct, $urandom_range(0, 199) == 0);
    end
    repeat (40) applyStimulus(0, '0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
